// File: rtl/wb_register_file.sv
// -----------------------------------------------------------------------------
// wb_register_file
//
// Writeback stage and integer register file of the five-stage RISC-V pipeline.
// Selects the writeback value (ALU result, load data or PC+4) from the
// memory/writeback pipeline register, commits it to a 32 x XLEN register file,
// and serves the two decode-stage read ports with same-cycle write-through
// bypass. A free-running counter records every committed register write.
//
// Ports
//   clk                          rising-edge clock
//   reset                        synchronous, active-high reset
//   alu_or_load_or_pc_plus_four  writeback select: 00 ALU, 01 load, 10 PC+4,
//                                11 reserved (bubble)
//   reg_write                    writeback enable from the pipeline register
//   rd_address                   destination register
//   alu_result                   ALU result
//   read_data                    load data from data memory
//   pc_plus_four                 return address for JAL/JALR
//   rs1_address, rs2_address     decode read port addresses
//   rs1_data, rs2_data           decode read port data (combinational)
//   wb_data                      selected writeback value (combinational)
//   wb_commit                    a write commits at the next edge (combinational)
//   write_count                  registered count of committed writes (wraps)
// -----------------------------------------------------------------------------
module wb_register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      alu_or_load_or_pc_plus_four,
    input  logic            reg_write,
    input  logic [4:0]      rd_address,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] pc_plus_four,
    input  logic [4:0]      rs1_address,
    input  logic [4:0]      rs2_address,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_commit,
    output logic [31:0]     write_count
);

    localparam logic [1:0] SEL_ALU      = 2'b00;
    localparam logic [1:0] SEL_LOAD     = 2'b01;
    localparam logic [1:0] SEL_PC4      = 2'b10;
    localparam logic [1:0] SEL_RESERVED = 2'b11;

    logic [XLEN-1:0] regs [0:NREGS-1];
    logic [31:0]     count;

    // Writeback source mux; the reserved encoding yields zero so a bubble
    // never shows stale data on wb_data.
    function automatic logic [XLEN-1:0] select_wb(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] load,
        input logic [XLEN-1:0] pc4
    );
        logic [XLEN-1:0] result;
        case (sel)
            SEL_ALU:  result = alu;
            SEL_LOAD: result = load;
            SEL_PC4:  result = pc4;
            default:  result = '0;
        endcase
        return result;
    endfunction

    // Read-port resolution: reset and x0 force zero, then the in-flight
    // writeback wins over the array so decode sees the value committing at
    // this edge without waiting a cycle.
    function automatic logic [XLEN-1:0] resolve_read(
        input logic            rst_active,
        input logic [4:0]      addr,
        input logic            commit,
        input logic [4:0]      wr_addr,
        input logic [XLEN-1:0] wr_data,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] result;
        if (rst_active || addr == 5'd0) begin
            result = '0;
        end else if (commit && addr == wr_addr) begin
            result = wr_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    always_comb begin
        wb_data   = select_wb(alu_or_load_or_pc_plus_four, alu_result,
                              read_data, pc_plus_four);
        wb_commit = reg_write && (rd_address != 5'd0)
                    && (alu_or_load_or_pc_plus_four != SEL_RESERVED) && !reset;
    end

    always_comb begin
        rs1_data = resolve_read(reset, rs1_address, wb_commit, rd_address,
                                wb_data, regs[rs1_address]);
        rs2_data = resolve_read(reset, rs2_address, wb_commit, rd_address,
                                wb_data, regs[rs2_address]);
    end

    // wb_commit already excludes reset, x0 and the reserved select, so the
    // array and counter only need to follow it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (wb_commit) begin
            regs[rd_address] <= wb_data;
            count            <= count + 32'd1;
        end
    end

    assign write_count = count;

endmodule

// File: tb/tb_wb_register_file.sv
// -----------------------------------------------------------------------------
// tb_wb_register_file
//
// Directed bench for wb_register_file. Inputs change just after the falling
// edge; combinational outputs are sampled 1 ns later, registered state is
// observed in the following cycle (after the next rising edge).
// -----------------------------------------------------------------------------
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic [1:0]  sel;
    logic        reg_write;
    logic [4:0]  rd_address;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus_four;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_commit;
    logic [31:0] write_count;

    int tests_run;
    int tests_failed;

    wb_register_file #(.XLEN(32), .NREGS(32)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .alu_or_load_or_pc_plus_four (sel),
        .reg_write                   (reg_write),
        .rd_address                  (rd_address),
        .alu_result                  (alu_result),
        .read_data                   (read_data),
        .pc_plus_four                (pc_plus_four),
        .rs1_address                 (rs1_address),
        .rs2_address                 (rs2_address),
        .rs1_data                    (rs1_data),
        .rs2_data                    (rs2_data),
        .wb_data                     (wb_data),
        .wb_commit                   (wb_commit),
        .write_count                 (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $display("FAIL %s: observed %08h expected %08h", tag, observed, expected);
            $error("check %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Advance to the falling edge and present a new input set.
    task automatic step(input logic rst, input logic [1:0] s, input logic we,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        reset        = rst;
        sel          = s;
        reg_write    = we;
        rd_address   = rd;
        alu_result   = alu;
        read_data    = ld;
        pc_plus_four = pc4;
        rs1_address  = ra1;
        rs2_address  = ra2;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1; sel = 2'b00; reg_write = 1'b0; rd_address = 5'd0;
        alu_result = '0; read_data = '0; pc_plus_four = '0;
        rs1_address = 5'd0; rs2_address = 5'd0;

        // Reset held two cycles with a write to x5 pending the whole time.
        step(1'b1, 2'b00, 1'b1, 5'd5, 32'h11, 32'h0, 32'h0, 5'd5, 5'd5);
        check("rst_commit", {31'b0, wb_commit}, 32'd0);
        check("rst_rs1", rs1_data, 32'd0);
        check("rst_wbdata", wb_data, 32'h11);
        step(1'b1, 2'b00, 1'b1, 5'd5, 32'h11, 32'h0, 32'h0, 5'd5, 5'd5);
        check("rst_rs2", rs2_data, 32'd0);
        check("rst_count", write_count, 32'd0);

        // Released: every address reads zero on both ports, x5 not written.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            check("init_rs1", rs1_data, 32'd0);
            check("init_rs2", rs2_data, 32'd0);
        end
        check("init_count", write_count, 32'd0);

        // ALU writeback to x3 with same-cycle bypass, then read from array.
        step(1'b0, 2'b00, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0, 32'h0, 5'd3, 5'd0);
        check("alu_bypass", rs1_data, 32'hDEADBEEF);
        check("alu_commit", {31'b0, wb_commit}, 32'd1);
        check("alu_wbdata", wb_data, 32'hDEADBEEF);
        step(1'b0, 2'b00, 1'b0, 5'd3, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
        check("alu_array", rs1_data, 32'hDEADBEEF);
        check("alu_count", write_count, 32'd1);

        // Load writeback to x7, PC+4 writeback to x8, read both together.
        step(1'b0, 2'b01, 1'b1, 5'd7, 32'h5555, 32'h12345678, 32'h0, 5'd0, 5'd0);
        check("load_wbdata", wb_data, 32'h12345678);
        step(1'b0, 2'b10, 1'b1, 5'd8, 32'h5555, 32'h12345678, 32'h104, 5'd7, 5'd8);
        check("pc4_wbdata", wb_data, 32'h00000104);
        check("pc4_rs1_x7", rs1_data, 32'h12345678);
        check("pc4_rs2_bypass", rs2_data, 32'h00000104);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd8);
        check("x7", rs1_data, 32'h12345678);
        check("x8", rs2_data, 32'h00000104);
        check("ld_pc4_count", write_count, 32'd3);

        // Write to x0 is dropped; x0 reads zero on both ports.
        step(1'b0, 2'b00, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        check("x0_commit", {31'b0, wb_commit}, 32'd0);
        check("x0_rs1", rs1_data, 32'd0);
        check("x0_rs2", rs2_data, 32'd0);
        // Reserved select to x9 is a bubble: no bypass, no write, no count.
        step(1'b0, 2'b11, 1'b1, 5'd9, 32'h99, 32'h99, 32'h99, 5'd9, 5'd0);
        check("x0_count", write_count, 32'd3);
        check("rsv_commit", {31'b0, wb_commit}, 32'd0);
        check("rsv_wbdata", wb_data, 32'd0);
        check("rsv_rs1", rs1_data, 32'd0);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
        check("x9", rs1_data, 32'd0);
        check("rsv_count", write_count, 32'd3);

        // Back-to-back writes to x12; bypass beats the older array value.
        step(1'b0, 2'b00, 1'b1, 5'd12, 32'hA, 32'h0, 32'h0, 5'd0, 5'd12);
        check("b2b_a", rs2_data, 32'hA);
        step(1'b0, 2'b00, 1'b1, 5'd12, 32'hB, 32'h0, 32'h0, 5'd12, 5'd12);
        check("b2b_b", rs2_data, 32'hB);
        check("b2b_b_rs1", rs1_data, 32'hB);
        step(1'b0, 2'b00, 1'b1, 5'd12, 32'hC, 32'h0, 32'h0, 5'd3, 5'd12);
        check("b2b_c", rs2_data, 32'hC);
        check("b2b_x3", rs1_data, 32'hDEADBEEF);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd12);
        check("x12", rs2_data, 32'hC);
        check("b2b_count", write_count, 32'd6);

        // Counter wrap: backdoor the counter to 0xFFFFFFFE, then two commits.
        force dut.count = 32'hFFFFFFFE;
        #1;
        release dut.count;
        #1;
        check("wrap_preset", write_count, 32'hFFFFFFFE);
        step(1'b0, 2'b00, 1'b1, 5'd13, 32'h1, 32'h0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 2'b00, 1'b1, 5'd14, 32'h2, 32'h0, 32'h0, 5'd0, 5'd0);
        check("wrap_max", write_count, 32'hFFFFFFFF);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd13, 5'd14);
        check("wrap_zero", write_count, 32'h00000000);
        check("x13", rs1_data, 32'h1);
        check("x14", rs2_data, 32'h2);

        // Second reset clears the array and the counter.
        step(1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd12);
        check("rst2_rs1", rs1_data, 32'd0);
        step(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd12);
        check("rst2_x3", rs1_data, 32'd0);
        check("rst2_x12", rs2_data, 32'd0);
        check("rst2_count", write_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
